// File: rtl/hazard_detection_unit_pkg.sv
// Shared CPU definitions used by the hazard detection unit.
//   REG_W       : register-specifier width
//   REG_ZERO    : specifier of the hard-wired zero register
//   hdu_state_t : hazard unit FSM states (RUN, MEM_WAIT)
package cpu_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hdu_state_t;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// Bundle of pipeline hazard inputs and stall/flush controls.
//   master : pipeline side, drives the ID/EX/MEM hazard inputs
//   slave  : hazard unit side, drives enables, flushes, bubbles, counters
interface hazard_detection_unit_if #(
   parameter int CNT_W = 32
);
   import cpu_pkg::*;

   logic [REG_W-1:0] IF_ID_RegRs;
   logic [REG_W-1:0] IF_ID_RegRt;
   logic             IF_ID_UsesRt;
   logic             ID_EX_MemRead;
   logic [REG_W-1:0] ID_EX_RegRt;
   logic             EX_BranchTaken;
   logic             EX_MEM_MemAccess;
   logic             DMem_Ready;
   logic             PC_Write;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Write;
   logic             ID_EX_Bubble;
   logic             EX_MEM_Write;
   logic             MEM_WB_Bubble;
   logic [CNT_W-1:0] Stall_Count;
   logic [CNT_W-1:0] Flush_Count;
   logic             Mem_Timeout;

   modport master (
      output IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_RegRt,
             EX_BranchTaken, EX_MEM_MemAccess, DMem_Ready,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
             EX_MEM_Write, MEM_WB_Bubble, Stall_Count, Flush_Count, Mem_Timeout
   );

   modport slave (
      input  IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_RegRt,
             EX_BranchTaken, EX_MEM_MemAccess, DMem_Ready,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
             EX_MEM_Write, MEM_WB_Bubble, Stall_Count, Flush_Count, Mem_Timeout
   );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count this cycle
//   count    : current (registered) count
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_r;

   // Count register, frozen once every bit is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, taken-branch
// flush and load-use stall, with saturating stall/flush counters and a sticky
// data-memory timeout flag.
//   clk, rst : clock and asynchronous active-high reset
//   hdu      : hazard inputs from ID/EX/MEM, stage enables/flushes/bubbles,
//              Stall_Count, Flush_Count, Mem_Timeout
module hazard_detection_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   hazard_detection_unit_if.slave  hdu
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V    = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] TIMEOUT_M1_V = WAIT_W'(MEM_TIMEOUT - 1);

   hdu_state_t        state_r, state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
   logic              mem_timeout_r;
   logic              timeout_set_s;
   logic              timeout_hit_s;
   logic              freeze_s, flush_s, load_use_s;
   logic              rs_match_s, rt_match_s;
   logic              pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s;
   logic              id_ex_bubble_s, ex_mem_write_s, mem_wb_bubble_s;

   // Hazard detection with priority: freeze > branch flush > load-use.
   always_comb begin
      // Once the wait has run MEM_TIMEOUT cycles the freeze is dropped for one
      // cycle so the pipeline can make progress.
      timeout_hit_s = (state_r == MEM_WAIT) && (wait_cnt_r == TIMEOUT_V);
      freeze_s      = hdu.EX_MEM_MemAccess && !hdu.DMem_Ready && !timeout_hit_s;
      flush_s       = !freeze_s && hdu.EX_BranchTaken;
      rs_match_s    = (hdu.ID_EX_RegRt == hdu.IF_ID_RegRs);
      rt_match_s    = hdu.IF_ID_UsesRt && (hdu.ID_EX_RegRt == hdu.IF_ID_RegRt);
      load_use_s    = !freeze_s && !hdu.EX_BranchTaken && hdu.ID_EX_MemRead &&
                      (hdu.ID_EX_RegRt != REG_ZERO) && (rs_match_s || rt_match_s);
   end

   // Stage enable / flush / bubble mux; everything held off while in reset.
   always_comb begin
      pc_write_s      = 1'b1;
      if_id_write_s   = 1'b1;
      if_id_flush_s   = 1'b0;
      id_ex_write_s   = 1'b1;
      id_ex_bubble_s  = 1'b0;
      ex_mem_write_s  = 1'b1;
      mem_wb_bubble_s = 1'b0;
      if (rst) begin
         pc_write_s     = 1'b0;
         if_id_write_s  = 1'b0;
         id_ex_write_s  = 1'b0;
         ex_mem_write_s = 1'b0;
      end else if (freeze_s) begin
         pc_write_s      = 1'b0;
         if_id_write_s   = 1'b0;
         id_ex_write_s   = 1'b0;
         ex_mem_write_s  = 1'b0;
         mem_wb_bubble_s = 1'b1;
      end else if (flush_s) begin
         if_id_flush_s  = 1'b1;
         id_ex_bubble_s = 1'b1;
      end else if (load_use_s) begin
         pc_write_s     = 1'b0;
         if_id_write_s  = 1'b0;
         id_ex_bubble_s = 1'b1;
      end else begin
         pc_write_s = 1'b1;
      end
   end

   // Next state and wait counter; the counter only runs while waiting.
   always_comb begin
      state_nxt_s    = RUN;
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
      timeout_set_s  = 1'b0;
      case (state_r)
         RUN: begin
            if (freeze_s) begin
               state_nxt_s = MEM_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (freeze_s) begin
               state_nxt_s    = MEM_WAIT;
               wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
               timeout_set_s  = (wait_cnt_r == TIMEOUT_M1_V);
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= RUN;
         wait_cnt_r    <= {WAIT_W{1'b0}};
         mem_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         mem_timeout_r <= mem_timeout_r || timeout_set_s;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze_s || load_use_s),
      .count (hdu.Stall_Count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_s),
      .count (hdu.Flush_Count)
   );

   assign hdu.PC_Write      = pc_write_s;
   assign hdu.IF_ID_Write   = if_id_write_s;
   assign hdu.IF_ID_Flush   = if_id_flush_s;
   assign hdu.ID_EX_Write   = id_ex_write_s;
   assign hdu.ID_EX_Bubble  = id_ex_bubble_s;
   assign hdu.EX_MEM_Write  = ex_mem_write_s;
   assign hdu.MEM_WB_Bubble = mem_wb_bubble_s;
   assign hdu.Mem_Timeout   = mem_timeout_r;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_detection_unit;
   // control vector order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
   //                       ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble
   localparam logic [6:0] C_RST    = 7'b0000000;
   localparam logic [6:0] C_DEF    = 7'b1101010;
   localparam logic [6:0] C_FREEZE = 7'b0000001;
   localparam logic [6:0] C_FLUSH  = 7'b1111110;
   localparam logic [6:0] C_LU     = 7'b0001110;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [6:0] ctrl;

   hazard_detection_unit_if #(.CNT_W(4)) bus ();

   hazard_detection_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .hdu (bus)
   );

   assign ctrl = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
                  bus.ID_EX_Bubble, bus.EX_MEM_Write, bus.MEM_WB_Bubble};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus.IF_ID_RegRs      = 5'd0;
      bus.IF_ID_RegRt      = 5'd0;
      bus.IF_ID_UsesRt     = 1'b0;
      bus.ID_EX_MemRead    = 1'b0;
      bus.ID_EX_RegRt      = 5'd0;
      bus.EX_BranchTaken   = 1'b0;
      bus.EX_MEM_MemAccess = 1'b0;
      bus.DMem_Ready       = 1'b1;
   endtask

   task automatic apply_reset();
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      #2;
      n_checks++;
      if (ctrl !== C_RST) begin
         n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST);
      end
      n_checks++;
      if (bus.Stall_Count !== 4'd0 || bus.Flush_Count !== 4'd0) begin
         n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.Stall_Count, bus.Flush_Count);
      end
      n_checks++;
      if (bus.Mem_Timeout !== 1'b0) begin
         n_fail++; $display("FAIL reset_timeout got=%b exp=0", bus.Mem_Timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (ctrl !== C_DEF) begin
         n_fail++; $display("FAIL post_reset_default got=%b exp=%b", ctrl, C_DEF);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegRt = 5'd8; bus.IF_ID_RegRs = 5'd8;
      #1;
      n_checks++;
      if (ctrl !== C_LU) begin
         n_fail++; $display("FAIL load_use_rs got=%b exp=%b", ctrl, C_LU);
      end
      @(negedge clk);
      bus.ID_EX_MemRead = 1'b0;
      #1;
      n_checks++;
      if (ctrl !== C_DEF || bus.Stall_Count !== 4'd1) begin
         n_fail++; $display("FAIL load_use_one_cycle got=%b/%0d exp=%b/1", ctrl, bus.Stall_Count, C_DEF);
      end
      bus.ID_EX_MemRead = 1'b1; bus.IF_ID_RegRs = 5'd3;
      bus.IF_ID_RegRt = 5'd8; bus.IF_ID_UsesRt = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== C_LU) begin
         n_fail++; $display("FAIL load_use_rt got=%b exp=%b", ctrl, C_LU);
      end
      @(negedge clk);
      set_idle();
      #1;
      n_checks++;
      if (bus.Stall_Count !== 4'd2) begin
         n_fail++; $display("FAIL load_use_count got=%0d exp=2", bus.Stall_Count);
      end
   endtask

   task automatic test_reg_zero();
      apply_reset();
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegRt = 5'd0; bus.IF_ID_RegRs = 5'd0;
      #1;
      n_checks++;
      if (ctrl !== C_DEF) begin
         n_fail++; $display("FAIL reg_zero got=%b exp=%b", ctrl, C_DEF);
      end
      @(negedge clk);
      bus.ID_EX_RegRt = 5'd9; bus.IF_ID_RegRt = 5'd9;
      bus.IF_ID_RegRs = 5'd1; bus.IF_ID_UsesRt = 1'b0;
      #1;
      n_checks++;
      if (ctrl !== C_DEF) begin
         n_fail++; $display("FAIL rt_unused got=%b exp=%b", ctrl, C_DEF);
      end
      @(negedge clk);
      set_idle();
      #1;
      n_checks++;
      if (bus.Stall_Count !== 4'd0) begin
         n_fail++; $display("FAIL no_stall_count got=%0d exp=0", bus.Stall_Count);
      end
   endtask

   task automatic test_branch_priority();
      apply_reset();
      bus.EX_BranchTaken = 1'b1;
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegRt = 5'd8; bus.IF_ID_RegRs = 5'd8;
      #1;
      n_checks++;
      if (ctrl !== C_FLUSH) begin
         n_fail++; $display("FAIL branch_over_load_use got=%b exp=%b", ctrl, C_FLUSH);
      end
      @(negedge clk);
      set_idle();
      #1;
      n_checks++;
      if (bus.Flush_Count !== 4'd1 || bus.Stall_Count !== 4'd0) begin
         n_fail++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", bus.Flush_Count, bus.Stall_Count);
      end
   endtask

   task automatic test_mem_wait();
      apply_reset();
      bus.EX_MEM_MemAccess = 1'b1; bus.DMem_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         // a branch and a load-use hazard during the freeze must be ignored
         bus.EX_BranchTaken = (i == 1);
         bus.ID_EX_MemRead = (i == 2); bus.ID_EX_RegRt = 5'd8; bus.IF_ID_RegRs = 5'd8;
         #1;
         n_checks++;
         if (ctrl !== C_FREEZE) begin
            n_fail++; $display("FAIL mem_freeze cyc=%0d got=%b exp=%b", i, ctrl, C_FREEZE);
         end
         @(negedge clk);
      end
      set_idle();
      bus.EX_MEM_MemAccess = 1'b1; bus.DMem_Ready = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== C_DEF || bus.Stall_Count !== 4'd3 || bus.Flush_Count !== 4'd0) begin
         n_fail++; $display("FAIL mem_release got=%b/%0d/%0d exp=%b/3/0", ctrl, bus.Stall_Count, bus.Flush_Count, C_DEF);
      end
      @(negedge clk);
      set_idle();
   endtask

   // c0 RUN, c1..c4 MEM_WAIT, c5 release, c6 freeze again
   task automatic test_timeout();
      apply_reset();
      bus.EX_MEM_MemAccess = 1'b1; bus.DMem_Ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         #1;
         n_checks++;
         if (ctrl !== ((c == 5) ? C_DEF : C_FREEZE)) begin
            n_fail++; $display("FAIL timeout_ctrl cyc=%0d got=%b exp=%b", c, ctrl, (c == 5) ? C_DEF : C_FREEZE);
         end
         n_checks++;
         if (bus.Mem_Timeout !== (c >= 5)) begin
            n_fail++; $display("FAIL timeout_flag cyc=%0d got=%b exp=%b", c, bus.Mem_Timeout, (c >= 5));
         end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (bus.Stall_Count !== 4'd6) begin
         n_fail++; $display("FAIL timeout_stall_count got=%0d exp=6", bus.Stall_Count);
      end
   endtask

   // entered in MEM_WAIT with Mem_Timeout set (continues test_timeout)
   task automatic test_async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== C_RST || bus.Stall_Count !== 4'd0 || bus.Mem_Timeout !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got=%b/%0d/%b exp=%b/0/0", ctrl, bus.Stall_Count, bus.Mem_Timeout, C_RST);
      end
      @(negedge clk);
      rst = 1'b0;
      // wait counter must start from zero again: full 5 freeze cycles
      for (int c = 0; c < 6; c++) begin
         #1;
         n_checks++;
         if (ctrl !== ((c == 5) ? C_DEF : C_FREEZE)) begin
            n_fail++; $display("FAIL rewait_ctrl cyc=%0d got=%b exp=%b", c, ctrl, (c == 5) ? C_DEF : C_FREEZE);
         end
         @(negedge clk);
      end
      set_idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (bus.Mem_Timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky cyc=%0d got=%b exp=1", c, bus.Mem_Timeout);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_RegRt = 5'd8; bus.IF_ID_RegRs = 5'd8;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 14) begin
            #1;
            n_checks++;
            if (bus.Stall_Count !== 4'd15) begin
               n_fail++; $display("FAIL sat_reach got=%0d exp=15", bus.Stall_Count);
            end
         end
      end
      set_idle();
      #1;
      n_checks++;
      if (bus.Stall_Count !== 4'd15) begin
         n_fail++; $display("FAIL sat_hold got=%0d exp=15", bus.Stall_Count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_load_use();
      test_reg_zero();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
